// File: rtl/alu_pkg.sv
// ALU operation codes and operand-select encodings shared by the
// decode and execute stages.
package alu_pkg;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SRA   = 4'd2;
  localparam logic [3:0] ALU_SRL   = 4'd3;
  localparam logic [3:0] ALU_SLL   = 4'd4;
  localparam logic [3:0] ALU_AND   = 4'd5;
  localparam logic [3:0] ALU_OR    = 4'd6;
  localparam logic [3:0] ALU_XOR   = 4'd7;
  localparam logic [3:0] ALU_SLT   = 4'd8;
  localparam logic [3:0] ALU_SLTU  = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  localparam logic A_SEL_RS1 = 1'b0;
  localparam logic A_SEL_PC  = 1'b1;
  localparam logic B_SEL_RS2 = 1'b0;
  localparam logic B_SEL_IMM = 1'b1;

endpackage

// File: rtl/fwd_mux.sv
// Forwarding select for one source operand: x0 reads as zero, otherwise
// the execute-stage result wins over the writeback value, which wins over
// the register file read.
module fwd_mux #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
) (
  input  logic [RADDR_W-1:0] src,
  input  logic [XLEN-1:0]    rf_data,
  input  logic               ex_wr_en,
  input  logic [RADDR_W-1:0] ex_rd_addr,
  input  logic [XLEN-1:0]    ex_data,
  input  logic               wb_wr_en,
  input  logic [RADDR_W-1:0] wb_rd_addr,
  input  logic [XLEN-1:0]    wb_data,
  output logic [XLEN-1:0]    data
);

  // Priority select: zero register, then EX, then WB, then regfile.
  always_comb begin
    data = rf_data;
    if (src == '0) begin
      data = '0;
    end else if (ex_wr_en && (ex_rd_addr == src)) begin
      data = ex_data;
    end else if (wb_wr_en && (wb_rd_addr == src)) begin
      data = wb_data;
    end
  end

endmodule

// File: rtl/ex_operand_stage.sv
// Decode-to-execute pipeline register. Resolves operand forwarding,
// selects ALU operands, inserts load-use bubbles and honours
// backpressure and branch flush.
module ex_operand_stage
  import alu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               id_valid,
  output logic               id_ready,
  input  logic [XLEN-1:0]    id_pc,
  input  logic [RADDR_W-1:0] id_rs1_addr,
  input  logic [RADDR_W-1:0] id_rs2_addr,
  input  logic               id_uses_rs1,
  input  logic               id_uses_rs2,
  input  logic [XLEN-1:0]    id_rs1_data,
  input  logic [XLEN-1:0]    id_rs2_data,
  input  logic [XLEN-1:0]    id_imm,
  input  logic               id_a_sel,
  input  logic               id_b_sel,
  input  logic [3:0]         id_alu_op,
  input  logic [RADDR_W-1:0] id_rd_addr,
  input  logic               id_reg_wr,
  input  logic               id_is_load,
  input  logic [XLEN-1:0]    ex_alu_result,
  input  logic               wb_reg_wr,
  input  logic [RADDR_W-1:0] wb_rd_addr,
  input  logic [XLEN-1:0]    wb_data,
  output logic               ex_valid,
  input  logic               ex_ready,
  output logic [XLEN-1:0]    ex_a,
  output logic [XLEN-1:0]    ex_b,
  output logic [3:0]         ex_alu_op,
  output logic [XLEN-1:0]    ex_store_data,
  output logic [XLEN-1:0]    ex_pc,
  output logic [RADDR_W-1:0] ex_rd_addr,
  output logic               ex_reg_wr,
  output logic               ex_is_load,
  output logic [CNT_W-1:0]   stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic            ex_fwd_en;
  logic            hazard;
  logic            accept;
  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;

  // A load's result is not yet available in EX, so it never forwards from here.
  assign ex_fwd_en = ex_valid & ex_reg_wr & ~ex_is_load;

  fwd_mux #(.XLEN(XLEN), .RADDR_W(RADDR_W)) u_fwd_rs1 (
    .src        (id_rs1_addr),
    .rf_data    (id_rs1_data),
    .ex_wr_en   (ex_fwd_en),
    .ex_rd_addr (ex_rd_addr),
    .ex_data    (ex_alu_result),
    .wb_wr_en   (wb_reg_wr),
    .wb_rd_addr (wb_rd_addr),
    .wb_data    (wb_data),
    .data       (fwd_rs1)
  );

  fwd_mux #(.XLEN(XLEN), .RADDR_W(RADDR_W)) u_fwd_rs2 (
    .src        (id_rs2_addr),
    .rf_data    (id_rs2_data),
    .ex_wr_en   (ex_fwd_en),
    .ex_rd_addr (ex_rd_addr),
    .ex_data    (ex_alu_result),
    .wb_wr_en   (wb_reg_wr),
    .wb_rd_addr (wb_rd_addr),
    .wb_data    (wb_data),
    .data       (fwd_rs2)
  );

  // Load-use hazard detection and the decode handshake.
  always_comb begin
    hazard = ex_valid & ex_is_load & ex_reg_wr & (ex_rd_addr != '0) & id_valid &
             ((id_uses_rs1 & (id_rs1_addr == ex_rd_addr)) |
              (id_uses_rs2 & (id_rs2_addr == ex_rd_addr)));
    id_ready = (~ex_valid | ex_ready) & ~hazard & ~flush;
    accept   = id_valid & id_ready;
  end

  // Pipeline register: reset, then flush, then accept, else drain on ready.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid      <= 1'b0;
      ex_a          <= '0;
      ex_b          <= '0;
      ex_alu_op     <= '0;
      ex_store_data <= '0;
      ex_pc         <= '0;
      ex_rd_addr    <= '0;
      ex_reg_wr     <= 1'b0;
      ex_is_load    <= 1'b0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (accept) begin
      ex_valid      <= 1'b1;
      ex_a          <= (id_a_sel == A_SEL_PC)  ? id_pc  : fwd_rs1;
      ex_b          <= (id_b_sel == B_SEL_IMM) ? id_imm : fwd_rs2;
      ex_alu_op     <= id_alu_op;
      ex_store_data <= fwd_rs2;
      ex_pc         <= id_pc;
      ex_rd_addr    <= id_rd_addr;
      ex_reg_wr     <= id_reg_wr;
      ex_is_load    <= id_is_load;
    end else if (ex_ready) begin
      ex_valid <= 1'b0;
    end
  end

  // Saturating count of cycles lost to load-use bubbles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (hazard && (ex_ready || !ex_valid) && !flush && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_ex_operand_stage.sv
// Bench for ex_operand_stage: directed scenarios plus randomized traffic
// checked against a transaction-level model of the stage.
module tb_ex_operand_stage;

  localparam int CNT_W = 4;

  logic        clk = 1'b0;
  logic        rst_n, flush, id_valid, id_ready;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic        id_uses_rs1, id_uses_rs2, id_a_sel, id_b_sel, id_reg_wr, id_is_load;
  logic [3:0]  id_alu_op;
  logic [31:0] ex_alu_result, wb_data;
  logic        wb_reg_wr;
  logic [4:0]  wb_rd_addr;
  logic        ex_valid, ex_ready;
  logic [31:0] ex_a, ex_b, ex_store_data, ex_pc;
  logic [3:0]  ex_alu_op;
  logic [4:0]  ex_rd_addr;
  logic        ex_reg_wr, ex_is_load;
  logic [CNT_W-1:0] stall_cnt;

  int vectors = 0;
  int miscompares = 0;

  // model of the instruction held in the stage
  logic        m_valid;
  logic [31:0] m_a, m_b, m_sd, m_pc;
  logic [3:0]  m_op;
  logic [4:0]  m_rd;
  logic        m_wr, m_ld;
  int          m_cnt;

  ex_operand_stage #(.XLEN(32), .RADDR_W(5), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_a_sel(id_a_sel), .id_b_sel(id_b_sel), .id_alu_op(id_alu_op),
    .id_rd_addr(id_rd_addr), .id_reg_wr(id_reg_wr), .id_is_load(id_is_load),
    .ex_alu_result(ex_alu_result), .wb_reg_wr(wb_reg_wr), .wb_rd_addr(wb_rd_addr),
    .wb_data(wb_data), .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_a(ex_a),
    .ex_b(ex_b), .ex_alu_op(ex_alu_op), .ex_store_data(ex_store_data), .ex_pc(ex_pc),
    .ex_rd_addr(ex_rd_addr), .ex_reg_wr(ex_reg_wr), .ex_is_load(ex_is_load),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // value an instruction in decode sees for register src
  function automatic logic [31:0] ref_fwd(input logic [4:0] src, input logic [31:0] rf);
    if (src == 5'd0) return 32'd0;
    if (m_valid && m_wr && !m_ld && m_rd == src) return ex_alu_result;
    if (wb_reg_wr && wb_rd_addr == src) return wb_data;
    return rf;
  endfunction

  function automatic logic ref_hazard();
    return m_valid && m_ld && m_wr && m_rd != 5'd0 && id_valid &&
           ((id_uses_rs1 && id_rs1_addr == m_rd) || (id_uses_rs2 && id_rs2_addr == m_rd));
  endfunction

  function automatic logic ref_ready();
    return !(m_valid && !ex_ready) && !ref_hazard() && !flush;
  endfunction

  task automatic set_idle();
    flush = 0; id_valid = 0; id_pc = 0; id_rs1_addr = 0; id_rs2_addr = 0;
    id_uses_rs1 = 0; id_uses_rs2 = 0; id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
    id_a_sel = 0; id_b_sel = 0; id_alu_op = 0; id_rd_addr = 0; id_reg_wr = 0;
    id_is_load = 0; ex_alu_result = 0; wb_reg_wr = 0; wb_rd_addr = 0; wb_data = 0;
    ex_ready = 1;
  endtask

  task automatic set_instr(input logic [31:0] pc, input logic [4:0] rs1, input logic [31:0] d1,
                           input logic [4:0] rs2, input logic [31:0] d2, input logic [31:0] imm,
                           input logic asel, input logic bsel, input logic [3:0] op,
                           input logic [4:0] rd, input logic wr, input logic ld);
    id_valid = 1; id_pc = pc; id_rs1_addr = rs1; id_rs1_data = d1; id_rs2_addr = rs2;
    id_rs2_data = d2; id_imm = imm; id_a_sel = asel; id_b_sel = bsel; id_alu_op = op;
    id_rd_addr = rd; id_reg_wr = wr; id_is_load = ld;
    id_uses_rs1 = !asel; id_uses_rs2 = 1;
  endtask

  // advance one clock, updating the model from the pre-edge inputs
  task automatic tick();
    logic acc, hz;
    logic [31:0] na, nb, nsd;
    hz  = ref_hazard();
    acc = id_valid && ref_ready();
    na  = id_a_sel ? id_pc : ref_fwd(id_rs1_addr, id_rs1_data);
    nb  = id_b_sel ? id_imm : ref_fwd(id_rs2_addr, id_rs2_data);
    nsd = ref_fwd(id_rs2_addr, id_rs2_data);
    @(posedge clk);
    if (!rst_n) begin
      m_valid = 0; m_a = 0; m_b = 0; m_sd = 0; m_pc = 0; m_op = 0;
      m_rd = 0; m_wr = 0; m_ld = 0; m_cnt = 0;
    end else begin
      if (hz && (ex_ready || !m_valid) && !flush && m_cnt < (1 << CNT_W) - 1) m_cnt++;
      if (flush) m_valid = 0;
      else if (acc) begin
        m_valid = 1; m_a = na; m_b = nb; m_sd = nsd; m_pc = id_pc; m_op = id_alu_op;
        m_rd = id_rd_addr; m_wr = id_reg_wr; m_ld = id_is_load;
      end else if (ex_ready) m_valid = 0;
    end
    #1;
  endtask

  task automatic do_reset();
    set_idle();
    rst_n = 0;
    tick();
    rst_n = 1;
  endtask

  task automatic test_reset();
    set_idle();
    rst_n = 0;
    tick();
    tick();
    vectors++;
    if ({ex_valid, ex_a, ex_b, ex_alu_op, ex_store_data, ex_pc, ex_rd_addr, ex_reg_wr, ex_is_load} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got valid=%0b a=%h b=%h pc=%h, need all zero", ex_valid, ex_a, ex_b, ex_pc);
    end
    vectors++;
    if (stall_cnt !== '0) begin
      miscompares++;
      $display("FAIL reset_stall_cnt: got %0d, need 0", stall_cnt);
    end
    rst_n = 1;
  endtask

  task automatic test_basic();
    do_reset();
    set_instr(32'h40, 5'd3, 32'd5, 5'd9, 32'd1, 32'd7, 0, 1, 4'd0, 5'd1, 1, 0);
    tick();
    vectors++;
    if (ex_valid !== 1'b1 || ex_a !== 32'd5 || ex_b !== 32'd7 || ex_alu_op !== 4'd0) begin
      miscompares++;
      $display("FAIL basic_issue: got v=%0b a=%h b=%h op=%0d, need v=1 a=5 b=7 op=0", ex_valid, ex_a, ex_b, ex_alu_op);
    end
  endtask

  task automatic test_forward();
    do_reset();
    set_instr(32'h80, 5'd1, 32'd0, 5'd2, 32'd0, 32'd0, 0, 0, 4'd0, 5'd3, 1, 0);
    tick();
    ex_alu_result = 32'h10; wb_reg_wr = 1; wb_rd_addr = 5'd3; wb_data = 32'h20;
    set_instr(32'h84, 5'd3, 32'h99, 5'd3, 32'h98, 32'd0, 0, 0, 4'd1, 5'd5, 1, 0);
    tick();
    vectors++;
    if (ex_a !== 32'h10 || ex_store_data !== 32'h10) begin
      miscompares++;
      $display("FAIL fwd_ex_priority: got a=%h sd=%h, need 00000010", ex_a, ex_store_data);
    end
    ex_alu_result = 32'h10;
    set_instr(32'h88, 5'd3, 32'h99, 5'd6, 32'h77, 32'd0, 0, 0, 4'd1, 5'd6, 1, 0);
    tick();
    vectors++;
    if (ex_a !== 32'h20 || ex_b !== 32'h77) begin
      miscompares++;
      $display("FAIL fwd_wb: got a=%h b=%h, need a=00000020 b=00000077", ex_a, ex_b);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    set_instr(32'h100, 5'd1, 32'd0, 5'd0, 32'd0, 32'd0, 0, 1, 4'd0, 5'd4, 1, 1);
    tick();
    set_instr(32'h104, 5'd0, 32'd0, 5'd4, 32'hABCD, 32'd0, 0, 0, 4'd0, 5'd8, 1, 0);
    #1;
    vectors++;
    if (id_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL loaduse_ready: got %0b, need 0", id_ready);
    end
    tick();
    vectors++;
    if (ex_valid !== 1'b0 || stall_cnt !== 4'd1) begin
      miscompares++;
      $display("FAIL loaduse_bubble: got v=%0b cnt=%0d, need v=0 cnt=1", ex_valid, stall_cnt);
    end
    vectors++;
    if (id_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL loaduse_release: got ready=%0b, need 1", id_ready);
    end
    tick();
    vectors++;
    if (ex_valid !== 1'b1 || ex_b !== 32'hABCD || ex_pc !== 32'h104 || stall_cnt !== 4'd1) begin
      miscompares++;
      $display("FAIL loaduse_accept: got v=%0b b=%h pc=%h cnt=%0d, need v=1 b=0000abcd pc=00000104 cnt=1",
               ex_valid, ex_b, ex_pc, stall_cnt);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    set_instr(32'h100, 5'd1, 32'h11, 5'd2, 32'h22, 32'h5, 1, 0, 4'd5, 5'd7, 1, 0);
    tick();
    ex_ready = 0;
    set_instr(32'h200, 5'd1, 32'h31, 5'd2, 32'h32, 32'h6, 0, 1, 4'd6, 5'd9, 1, 1);
    for (int i = 0; i < 3; i++) begin
      ex_alu_result = $urandom;
      #1;
      vectors++;
      if (id_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_ready cycle %0d: got %0b, need 0", i, id_ready);
      end
      tick();
      vectors++;
      if (ex_valid !== 1'b1 || ex_a !== 32'h100 || ex_b !== 32'h22 || ex_store_data !== 32'h22 ||
          ex_alu_op !== 4'd5 || ex_pc !== 32'h100 || ex_rd_addr !== 5'd7 || ex_reg_wr !== 1'b1 ||
          ex_is_load !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_hold cycle %0d: got v=%0b a=%h b=%h op=%0d pc=%h rd=%0d, need v=1 a=00000100 b=00000022 op=5 pc=00000100 rd=7",
                 i, ex_valid, ex_a, ex_b, ex_alu_op, ex_pc, ex_rd_addr);
      end
    end
    ex_ready = 1;
    #1;
    vectors++;
    if (id_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_release: got %0b, need 1", id_ready);
    end
    tick();
    vectors++;
    if (ex_valid !== 1'b1 || ex_pc !== 32'h200 || ex_b !== 32'h6 || ex_is_load !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_next: got v=%0b pc=%h b=%h ld=%0b, need v=1 pc=00000200 b=00000006 ld=1",
               ex_valid, ex_pc, ex_b, ex_is_load);
    end
  endtask

  task automatic test_flush();
    do_reset();
    set_instr(32'h300, 5'd1, 32'd0, 5'd0, 32'd0, 32'd0, 0, 1, 4'd0, 5'd4, 1, 1);
    tick();
    set_instr(32'h304, 5'd4, 32'd0, 5'd0, 32'd0, 32'd0, 0, 1, 4'd0, 5'd5, 1, 0);
    flush = 1;
    #1;
    vectors++;
    if (id_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_ready: got %0b, need 0", id_ready);
    end
    tick();
    vectors++;
    if (ex_valid !== 1'b0 || stall_cnt !== 4'd0) begin
      miscompares++;
      $display("FAIL flush_kill: got v=%0b cnt=%0d, need v=0 cnt=0", ex_valid, stall_cnt);
    end
    flush = 0;
  endtask

  task automatic test_x0();
    do_reset();
    wb_reg_wr = 1; wb_rd_addr = 5'd0; wb_data = 32'hFFFF_FFFF;
    set_instr(32'h400, 5'd0, 32'h1234, 5'd0, 32'h5678, 32'd0, 0, 0, 4'd0, 5'd0, 1, 0);
    tick();
    vectors++;
    if (ex_a !== 32'd0 || ex_b !== 32'd0 || ex_store_data !== 32'd0) begin
      miscompares++;
      $display("FAIL x0_zero: got a=%h b=%h sd=%h, need all 0", ex_a, ex_b, ex_store_data);
    end
  endtask

  task automatic test_reset_midstall();
    do_reset();
    set_instr(32'h500, 5'd1, 32'd0, 5'd0, 32'd0, 32'd9, 0, 1, 4'd2, 5'd6, 1, 1);
    tick();
    set_instr(32'h504, 5'd6, 32'd0, 5'd0, 32'd0, 32'd0, 0, 1, 4'd3, 5'd7, 1, 0);
    tick();
    rst_n = 0;
    tick();
    vectors++;
    if ({ex_valid, ex_a, ex_b, ex_alu_op, ex_store_data, ex_pc, ex_rd_addr, ex_reg_wr, ex_is_load, stall_cnt} !== '0) begin
      miscompares++;
      $display("FAIL reset_midstall: got v=%0b pc=%h a=%h cnt=%0d, need all zero", ex_valid, ex_pc, ex_a, stall_cnt);
    end
    rst_n = 1;
  endtask

  task automatic test_saturate();
    do_reset();
    set_instr(32'h600, 5'd4, 32'd0, 5'd0, 32'd0, 32'd0, 0, 1, 4'd0, 5'd4, 1, 1);
    id_uses_rs2 = 0;
    for (int i = 0; i < 40; i++) tick();
    vectors++;
    if (stall_cnt !== 4'hF || m_cnt != 15) begin
      miscompares++;
      $display("FAIL stall_saturate: got %0d, need 15", stall_cnt);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst_n         = ($urandom_range(99) != 0);
      flush         = ($urandom_range(19) == 0);
      id_valid      = ($urandom_range(9) < 8);
      ex_ready      = ($urandom_range(3) != 0);
      id_pc         = $urandom;
      id_rs1_addr   = 5'($urandom_range(7));
      id_rs2_addr   = 5'($urandom_range(7));
      id_uses_rs1   = 1'($urandom);
      id_uses_rs2   = 1'($urandom);
      id_rs1_data   = $urandom;
      id_rs2_data   = $urandom;
      id_imm        = $urandom;
      id_a_sel      = 1'($urandom);
      id_b_sel      = 1'($urandom);
      id_alu_op     = 4'($urandom_range(10));
      id_rd_addr    = 5'($urandom_range(7));
      id_reg_wr     = ($urandom_range(3) != 0);
      id_is_load    = ($urandom_range(9) < 3);
      ex_alu_result = $urandom;
      wb_reg_wr     = 1'($urandom);
      wb_rd_addr    = 5'($urandom_range(7));
      wb_data       = $urandom;
      #1;
      vectors++;
      if (id_ready !== ref_ready()) begin
        miscompares++;
        $display("FAIL rand_id_ready iter %0d: got %0b, need %0b", i, id_ready, ref_ready());
      end
      tick();
      vectors++;
      if (ex_valid !== m_valid || stall_cnt !== CNT_W'(m_cnt)) begin
        miscompares++;
        $display("FAIL rand_valid_cnt iter %0d: got v=%0b cnt=%0d, need v=%0b cnt=%0d", i, ex_valid, stall_cnt, m_valid, m_cnt);
      end
      if (m_valid) begin
        vectors++;
        if (ex_a !== m_a || ex_b !== m_b || ex_store_data !== m_sd || ex_alu_op !== m_op ||
            ex_pc !== m_pc || ex_rd_addr !== m_rd || ex_reg_wr !== m_wr || ex_is_load !== m_ld) begin
          miscompares++;
          $display("FAIL rand_data iter %0d: got a=%h b=%h sd=%h op=%0d pc=%h rd=%0d wr=%0b ld=%0b, need a=%h b=%h sd=%h op=%0d pc=%h rd=%0d wr=%0b ld=%0b",
                   i, ex_a, ex_b, ex_store_data, ex_alu_op, ex_pc, ex_rd_addr, ex_reg_wr, ex_is_load,
                   m_a, m_b, m_sd, m_op, m_pc, m_rd, m_wr, m_ld);
        end
      end
    end
    rst_n = 1;
  endtask

  initial begin
    rst_n = 0;
    set_idle();
    m_valid = 0; m_a = 0; m_b = 0; m_sd = 0; m_pc = 0; m_op = 0;
    m_rd = 0; m_wr = 0; m_ld = 0; m_cnt = 0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_forward();
    test_load_use();
    test_backpressure();
    test_flush();
    test_x0();
    test_reset_midstall();
    test_saturate();
    do_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
